// File: rtl/itim_nway_pkg.sv
// Shared types and size helpers for the N-way instruction TIM controller.
// Bus structs, controller state encoding and geometry defaults live here.
package itim_nway_wires;

    localparam int          ITIM_WAYS_DEF  = 2;
    localparam int          ITIM_DEPTH_DEF = 6;
    localparam int          ITIM_WIDTH_DEF = 2;
    localparam logic [31:0] ITIM_BASE_ADDR = 32'h0000_0000;
    localparam logic [31:0] ITIM_TOP_ADDR  = 32'h0001_0000;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic [31:0] mem_rdata;
        logic        mem_ready;
    } mem_out_type;

    typedef enum logic [2:0] {
        HIT    = 3'd0,
        MISS   = 3'd1,
        LOAD   = 3'd2,
        UPDATE = 3'd3,
        FENCE  = 3'd4
    } itim_state_t;

    function automatic int way_w_f(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int tag_w_f(input int depth, input int width);
        return 32 - depth - width - 2;
    endfunction

    function automatic int line_w_f(input int width);
        return 32 * (1 << width);
    endfunction

endpackage

// File: rtl/itim_nway_ram.sv
// Simple dual-port RAM: one write port, one read port with registered read data.
// A same-cycle write and read to one address returns the old contents.
module itim_nway_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [1 << ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // Storage write and read-first data capture; contents are never reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/itim_nway.sv
// N-way set-associative instruction TIM controller with round-robin replacement,
// flop-held valid bits, single-cycle fence invalidation and an uncached bypass.
module itim_nway
    import itim_nway_wires::*;
#(
    parameter int          itim_ways  = ITIM_WAYS_DEF,
    parameter int          itim_depth = ITIM_DEPTH_DEF,
    parameter int          itim_width = ITIM_WIDTH_DEF,
    parameter logic [31:0] base_addr  = ITIM_BASE_ADDR,
    parameter logic [31:0] top_addr   = ITIM_TOP_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  mem_in_type  itim_in,
    output mem_out_type itim_out,
    input  mem_out_type imem_out,
    output mem_in_type  imem_in
);

    localparam int SETS   = 1 << itim_depth;
    localparam int WORDS  = 1 << itim_width;
    localparam int TAG_W  = tag_w_f(itim_depth, itim_width);
    localparam int LINE_W = line_w_f(itim_width);
    localparam int WAY_W  = way_w_f(itim_ways);
    localparam int SET_LO = itim_width + 2;
    localparam int TAG_LO = itim_depth + itim_width + 2;

    itim_state_t        r_state;
    logic               r_lookup;
    logic               r_fence_done;
    logic [31:0]        r_addr;
    logic [31:0]        r_fill_addr;
    logic [WAY_W-1:0]   r_victim;
    logic               r_victim_free;
    logic [31:0]        r_line  [WORDS];
    logic [SETS-1:0]    r_valid [itim_ways];
    logic [WAY_W-1:0]   r_ptr   [SETS];

    logic [itim_depth-1:0] w_req_set;
    logic [itim_depth-1:0] w_set;
    logic [TAG_W-1:0]      w_tag;
    logic [itim_width-1:0] w_word;
    logic [TAG_W-1:0]      w_tag_rd  [itim_ways];
    logic [LINE_W-1:0]     w_data_rd [itim_ways];
    logic [itim_ways-1:0]  w_we;
    logic [itim_ways-1:0]  w_hit_vec;
    logic [LINE_W-1:0]     w_hit_line;
    logic [LINE_W-1:0]     w_line_flat;
    logic                  w_hit;
    logic                  w_free_found;
    logic [WAY_W-1:0]      w_free_way;
    logic                  w_uncached;
    logic                  w_unused;

    assign w_req_set  = itim_in.mem_addr[TAG_LO-1:SET_LO];
    assign w_set      = r_addr[TAG_LO-1:SET_LO];
    assign w_tag      = r_addr[31:TAG_LO];
    assign w_word     = r_addr[SET_LO-1:2];
    assign w_uncached = (itim_in.mem_addr < base_addr) || (itim_in.mem_addr >= top_addr);
    assign w_hit      = r_lookup && (|w_hit_vec);
    assign w_unused   = ^{itim_in.mem_instr, itim_in.mem_wdata, itim_in.mem_wstrb,
                          r_addr[1:0], r_fill_addr[1:0]};

    for (genvar g = 0; g < itim_ways; g++) begin : g_way
        assign w_we[g] = (r_state == UPDATE) && (r_victim == WAY_W'(g));

        itim_nway_ram #(.DATA_W(TAG_W), .ADDR_W(itim_depth)) u_tag (
            .clk     (clk),
            .i_we    (w_we[g]),
            .i_waddr (w_set),
            .i_wdata (w_tag),
            .i_raddr (w_req_set),
            .o_rdata (w_tag_rd[g])
        );

        itim_nway_ram #(.DATA_W(LINE_W), .ADDR_W(itim_depth)) u_data (
            .clk     (clk),
            .i_we    (w_we[g]),
            .i_waddr (w_set),
            .i_wdata (w_line_flat),
            .i_raddr (w_req_set),
            .o_rdata (w_data_rd[g])
        );
    end

    // Tag compare across ways, and victim choice preferring the lowest invalid way.
    always_comb begin
        w_hit_vec    = {itim_ways{1'b0}};
        w_hit_line   = {LINE_W{1'b0}};
        w_free_found = 1'b0;
        w_free_way   = {WAY_W{1'b0}};
        for (int w = itim_ways - 1; w >= 0; w--) begin
            if (r_valid[w][w_set] && (w_tag_rd[w] == w_tag)) begin
                w_hit_vec[w] = 1'b1;
                w_hit_line   = w_data_rd[w];
            end else begin
                w_hit_vec[w] = 1'b0;
            end
            if (!r_valid[w][w_set]) begin
                w_free_found = 1'b1;
                w_free_way   = WAY_W'(w);
            end else begin
                w_free_found = w_free_found;
            end
        end
    end

    // Flatten the refill buffer into the data RAM write word.
    always_comb begin
        w_line_flat = {LINE_W{1'b0}};
        for (int i = 0; i < WORDS; i++) begin
            w_line_flat[i*32 +: 32] = r_line[i];
        end
    end

    // Fetch-side response and backing-memory request, decoded from registered state.
    always_comb begin
        itim_out           = '{mem_rdata: 32'h0, mem_ready: 1'b0};
        imem_in.mem_valid  = 1'b0;
        imem_in.mem_fence  = 1'b0;
        imem_in.mem_instr  = 1'b1;
        imem_in.mem_addr   = 32'h0;
        imem_in.mem_wdata  = 32'h0;
        imem_in.mem_wstrb  = 4'h0;
        case (r_state)
            HIT: begin
                if (r_fence_done) begin
                    itim_out.mem_ready = 1'b1;
                end else if (w_hit) begin
                    itim_out.mem_ready = 1'b1;
                    itim_out.mem_rdata = w_hit_line[{w_word, 5'b00000} +: 32];
                end else begin
                    itim_out.mem_ready = 1'b0;
                end
            end
            MISS: begin
                imem_in.mem_valid = 1'b1;
                imem_in.mem_addr  = r_fill_addr;
            end
            LOAD: begin
                imem_in.mem_valid  = 1'b1;
                imem_in.mem_addr   = r_addr;
                itim_out.mem_ready = imem_out.mem_ready;
                itim_out.mem_rdata = imem_out.mem_rdata;
            end
            UPDATE: begin
                itim_out.mem_ready = 1'b1;
                itim_out.mem_rdata = r_line[w_word];
            end
            FENCE: begin
                itim_out.mem_ready = 1'b0;
            end
            default: begin
                itim_out.mem_ready = 1'b0;
            end
        endcase
    end

    // Controller FSM, refill buffer, valid bits and per-set victim pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= HIT;
            r_lookup      <= 1'b0;
            r_fence_done  <= 1'b0;
            r_addr        <= 32'h0;
            r_fill_addr   <= 32'h0;
            r_victim      <= {WAY_W{1'b0}};
            r_victim_free <= 1'b0;
            for (int i = 0; i < WORDS; i++) r_line[i] <= 32'h0;
            for (int w = 0; w < itim_ways; w++) r_valid[w] <= {SETS{1'b0}};
            for (int s = 0; s < SETS; s++) r_ptr[s] <= {WAY_W{1'b0}};
        end else begin
            case (r_state)
                HIT: begin
                    r_lookup     <= 1'b0;
                    r_fence_done <= 1'b0;
                    if (r_lookup) begin
                        if (!w_hit) begin
                            r_state       <= MISS;
                            r_fill_addr   <= {r_addr[31:SET_LO], {SET_LO{1'b0}}};
                            r_victim      <= w_free_found ? w_free_way : r_ptr[w_set];
                            r_victim_free <= w_free_found;
                        end else begin
                            r_state <= HIT;
                        end
                    end else if (r_fence_done) begin
                        r_state <= HIT;
                    end else if (itim_in.mem_valid) begin
                        r_addr <= itim_in.mem_addr;
                        if (itim_in.mem_fence) begin
                            r_state <= FENCE;
                            for (int w = 0; w < itim_ways; w++) r_valid[w] <= {SETS{1'b0}};
                            for (int s = 0; s < SETS; s++) r_ptr[s] <= {WAY_W{1'b0}};
                        end else if (w_uncached) begin
                            r_state <= LOAD;
                        end else begin
                            r_lookup <= 1'b1;
                        end
                    end else begin
                        r_state <= HIT;
                    end
                end
                MISS: begin
                    if (imem_out.mem_ready) begin
                        r_line[r_fill_addr[SET_LO-1:2]] <= imem_out.mem_rdata;
                        r_fill_addr <= r_fill_addr + 32'd4;
                        if (&r_fill_addr[SET_LO-1:2]) begin
                            r_state <= UPDATE;
                        end else begin
                            r_state <= MISS;
                        end
                    end else begin
                        r_state <= MISS;
                    end
                end
                UPDATE: begin
                    r_valid[r_victim][w_set] <= 1'b1;
                    if (!r_victim_free) begin
                        r_ptr[w_set] <= (r_ptr[w_set] == WAY_W'(itim_ways - 1)) ?
                                        {WAY_W{1'b0}} : r_ptr[w_set] + {{(WAY_W-1){1'b0}}, 1'b1};
                    end else begin
                        r_ptr[w_set] <= r_ptr[w_set];
                    end
                    r_state <= HIT;
                end
                LOAD: begin
                    if (imem_out.mem_ready) begin
                        r_state <= HIT;
                    end else begin
                        r_state <= LOAD;
                    end
                end
                FENCE: begin
                    r_fence_done <= 1'b1;
                    r_state      <= HIT;
                end
                default: begin
                    r_state <= HIT;
                end
            endcase
        end
    end

endmodule
